// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock)
// with valid/ready handshakes on both the input and the result.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned ACC_W = 4 * DIGITS;

    // 10^n, saturating at all-ones so large DIGITS values still compare sanely
    function automatic logic [63:0] pow10_sat(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = (r > 64'd1844674407370955161) ? '1 : r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_BIN = (64'd1 << BIN_W) - 64'd1;

    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W must be in 1..32");
    end
    if (pow10_sat(DIGITS) <= MAX_BIN) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small to hold 2^BIN_W-1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   adj_c;
    logic [ACC_W-1:0]   shifted_c;

    // Add-3 correction on every digit >= 5, then shift in the next binary MSB
    always_comb begin
        adj_c = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            adj_c[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                        : acc_q[4*i +: 4];
        end
        shifted_c = {adj_c[ACC_W-2:0], bin_q[BIN_W-1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = shifted_c;
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = shifted_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake flags are registered copies of the next-state decode
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d == S_SHIFT);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            acc_q       <= '0;
            bcd_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            bcd_q       <= bcd_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;

endmodule
